product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 21 ++
 rtl/acc_adder.sv | 18 +
 rtl/product_accumulator.sv | 141 ++++++++++++++
 tb/tb_product_accumulator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the block product accumulator.
package product_accumulator_pkg;

    // Default accumulator width and products per block.
    localparam int ACC_W_DEF     = 72;
    localparam int BLOCK_LEN_DEF = 8;

    // Width of the per-block product counter and of out_count.
    localparam int CNT_W = 8;

    // Width of the incoming multiplier product.
    localparam int PROD_W = 64;

    // Block life cycle: empty, partially filled, result presented.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit accumulator adder with carry-out; the product is zero-extended.
module acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    // One extra bit on the adder captures the carry out of the top bit.
    always_comb begin
        {carry_o, sum_o} = (ACC_W + 1)'(acc_i) + (ACC_W + 1)'(prod_i);
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of unsigned 64-bit products and presents each block result
// with a valid/ready handshake; a block closes when full or on flush.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_prod,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               ready_q;

    logic               accept_s;
    logic [ACC_W-1:0]   sum_s;
    logic               carry_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_acc_adder (
        .acc_i   (acc_q),
        .prod_i  (in_prod),
        .sum_o   (sum_s),
        .carry_o (carry_s)
    );

    // Accept qualifier and the count after a potential accept.
    always_comb begin
        accept_s  = in_valid && ready_q;
        cnt_inc_s = cnt_q + 8'd1;
    end

    // State and datapath registers; in_ready is held low through reset and
    // rises on the first edge after reset, low whenever the block is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d != ST_HOLD);
        end
    end

    // Next-state and next-datapath logic; flush only matters in ACCUM so an
    // empty block is never emitted.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    acc_d = ACC_W'(in_prod);
                    cnt_d = 8'd1;
                    ovf_d = 1'b0;
                    if (BLOCK_LEN_C == 8'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = sum_s;
                    cnt_d = cnt_inc_s;
                    ovf_d = ovf_q | carry_s;
                    if ((cnt_inc_s == BLOCK_LEN_C) || flush) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else if (flush) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Outputs decoded from registered state; result fields read as zero
    // unless a result is being presented.
    always_comb begin
        in_ready  = ready_q;
        out_valid = (state_q == ST_HOLD);
        if (state_q == ST_HOLD) begin
            out_sum   = acc_q;
            out_count = cnt_q;
            out_ovf   = ovf_q;
        end else begin
            out_sum   = {ACC_W{1'b0}};
            out_count = 8'd0;
            out_ovf   = 1'b0;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (72/8, 64/8, 72/1) share
// stimulus; each is compared every cycle against a block-level model, and
// directed tables/sequences check the documented corner cases.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_prod;
    logic        flush;
    logic        out_ready;

    logic        a_ready, a_valid, a_ovf;
    logic [71:0] a_sum;
    logic [7:0]  a_count;
    logic        b_ready, b_valid, b_ovf;
    logic [63:0] b_sum;
    logic [7:0]  b_count;
    logic        c_ready, c_valid, c_ovf;
    logic [71:0] c_sum;
    logic [7:0]  c_count;

    int checks;
    int errors;

    product_accumulator #(.ACC_W(72), .BLOCK_LEN(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_prod(in_prod), .flush(flush), .out_valid(a_valid),
        .out_ready(out_ready), .out_sum(a_sum), .out_count(a_count),
        .out_ovf(a_ovf));

    product_accumulator #(.ACC_W(64), .BLOCK_LEN(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_prod(in_prod), .flush(flush), .out_valid(b_valid),
        .out_ready(out_ready), .out_sum(b_sum), .out_count(b_count),
        .out_ovf(b_ovf));

    product_accumulator #(.ACC_W(72), .BLOCK_LEN(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready),
        .in_prod(in_prod), .flush(flush), .out_valid(c_valid),
        .out_ready(out_ready), .out_sum(c_sum), .out_count(c_count),
        .out_ovf(c_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-level model: exact (unbounded) block total and product count,
    // plus whether a result is pending. Overflow is "total >= 2^W".
    int           mw  [3] = '{72, 64, 72};
    int           mbl [3] = '{8, 8, 1};
    bit           m_pend  [3];
    bit           m_ready [3];
    int           m_n     [3];
    logic [135:0] m_tot   [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i]  = 1'b0;
            m_ready[i] = 1'b0;
            m_n[i]     = 0;
            m_tot[i]   = 136'd0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_pend[i]) begin
                    if (out_ready) begin
                        m_pend[i] = 1'b0;
                        m_n[i]    = 0;
                        m_tot[i]  = 136'd0;
                    end
                end else begin
                    bit took;
                    int was_open;
                    was_open = m_n[i];
                    took = in_valid && m_ready[i];
                    if (took) begin
                        m_n[i]   = m_n[i] + 1;
                        m_tot[i] = m_tot[i] + 136'(in_prod);
                    end
                    if ((took && m_n[i] == mbl[i]) || (flush && was_open > 0))
                        m_pend[i] = 1'b1;
                end
                m_ready[i] = !m_pend[i];
            end
        end
    endtask

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input string tag, input int i, input logic v, input logic r,
                                input logic [135:0] s, input logic [7:0] c, input logic o);
        logic [135:0] mask;
        mask = (136'd1 << mw[i]) - 136'd1;
        chk({tag, ".out_valid"}, 136'(v), 136'(m_pend[i]));
        chk({tag, ".in_ready"},  136'(r), 136'(m_ready[i]));
        chk({tag, ".out_sum"},   s, m_pend[i] ? (m_tot[i] & mask) : 136'd0);
        chk({tag, ".out_count"}, 136'(c), m_pend[i] ? 136'(m_n[i]) : 136'd0);
        chk({tag, ".out_ovf"},   136'(o),
            136'(m_pend[i] && ((m_tot[i] >> mw[i]) != 136'd0)));
    endtask

    task automatic compare_all();
        compare_inst("A", 0, a_valid, a_ready, 136'(a_sum), a_count, a_ovf);
        compare_inst("B", 1, b_valid, b_ready, 136'(b_sum), b_count, b_ovf);
        compare_inst("C", 2, c_valid, c_ready, 136'(c_sum), c_count, c_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic [63:0] p, input logic f, input logic r);
        in_valid  = v;
        in_prod   = p;
        flush     = f;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        model_reset();
        compare_all();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("ready_after_reset", 136'(a_ready), 136'd1);
    endtask

    typedef struct {
        logic        vld;
        logic [63:0] prod;
        logic        fl;
        logic        ordy;
        logic        e_valid;
        logic        e_ready;
        logic [71:0] e_sum;
        logic [7:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t vt[$];

    localparam logic [63:0] P62  = 64'h4000_0000_0000_0000;
    localparam logic [71:0] S65  = 72'h02_0000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        set_in(1'b0, 64'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        do_reset();

        // Full block of 2^62 products, then flush-closed blocks on A.
        for (int k = 0; k < 7; k++)
            vt.push_back('{1'b1, P62, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, P62, 1'b0, 1'b0, 1'b1, 1'b0, S65, 8'd8, 1'b0});
        vt.push_back('{1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, S65, 8'd8, 1'b0});
        vt.push_back('{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 72'd6, 8'd3, 1'b0});
        vt.push_back('{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});
        vt.push_back('{1'b1, 64'd4, 1'b1, 1'b0, 1'b1, 1'b0, 72'd10, 8'd4, 1'b0});
        vt.push_back('{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd0, 8'd0, 1'b0});

        foreach (vt[k]) begin
            set_in(vt[k].vld, vt[k].prod, vt[k].fl, vt[k].ordy);
            cycle();
            chk($sformatf("vec%0d.out_valid", k), 136'(a_valid), 136'(vt[k].e_valid));
            chk($sformatf("vec%0d.in_ready", k),  136'(a_ready), 136'(vt[k].e_ready));
            chk($sformatf("vec%0d.out_sum", k),   136'(a_sum),   136'(vt[k].e_sum));
            chk($sformatf("vec%0d.out_count", k), 136'(a_count), 136'(vt[k].e_cnt));
            chk($sformatf("vec%0d.out_ovf", k),   136'(a_ovf),   136'(vt[k].e_ovf));
        end

        // 64-bit overflow on B, then a clean block clears ovf.
        set_in(1'b1, ONES, 1'b0, 1'b0); cycle();
        set_in(1'b1, ONES, 1'b1, 1'b0); cycle();
        chk("ovf.b_valid", 136'(b_valid), 136'd1);
        chk("ovf.b_sum",   136'(b_sum),   136'h0_FFFF_FFFF_FFFF_FFFE);
        chk("ovf.b_ovf",   136'(b_ovf),   136'd1);
        chk("ovf.b_count", 136'(b_count), 136'd2);
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();
        set_in(1'b1, 64'd5, 1'b0, 1'b0); cycle();
        set_in(1'b1, 64'd5, 1'b1, 1'b0); cycle();
        chk("ovf2.b_valid", 136'(b_valid), 136'd1);
        chk("ovf2.b_sum",   136'(b_sum),   136'd10);
        chk("ovf2.b_ovf",   136'(b_ovf),   136'd0);
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();

        // Backpressure on A: held result stays put and input is refused.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 64'd3, 1'b0, 1'b0); cycle();
        end
        chk("bp.valid", 136'(a_valid), 136'd1);
        for (int k = 0; k < 5; k++) begin
            set_in(k % 2 == 0, 64'd100, 1'b0, 1'b0); cycle();
            chk("bp.sum",   136'(a_sum),   136'd24);
            chk("bp.count", 136'(a_count), 136'd8);
            chk("bp.ready", 136'(a_ready), 136'd0);
        end
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();
        chk("bp.release", 136'(a_valid), 136'd0);
        set_in(1'b1, 64'd7, 1'b0, 1'b0); cycle();
        set_in(1'b0, 64'd0, 1'b1, 1'b0); cycle();
        chk("bp.next_sum",   136'(a_sum),   136'd7);
        chk("bp.next_count", 136'(a_count), 136'd1);
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();

        // Reset in the middle of a block discards it.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 64'd1, 1'b0, 1'b0); cycle();
        end
        rst = 1'b1;
        set_in(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        model_reset();
        compare_all();
        chk("rst.valid", 136'(a_valid), 136'd0);
        chk("rst.ready", 136'(a_ready), 136'd0);
        chk("rst.sum",   136'(a_sum),   136'd0);
        cycle();
        rst = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 64'd1, 1'b0, 1'b0); cycle();
        end
        chk("rst.new_sum",   136'(a_sum),   136'd8);
        chk("rst.new_count", 136'(a_count), 136'd8);
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();

        // BLOCK_LEN=1 on C: flush in IDLE is ignored, each accept closes.
        set_in(1'b0, 64'd0, 1'b1, 1'b0); cycle();
        chk("bl1.flush_idle", 136'(c_valid), 136'd0);
        set_in(1'b0, 64'd0, 1'b0, 1'b0); cycle();
        chk("bl1.flush_idle2", 136'(c_valid), 136'd0);
        set_in(1'b1, 64'd9, 1'b0, 1'b0); cycle();
        chk("bl1.valid", 136'(c_valid), 136'd1);
        chk("bl1.count", 136'(c_count), 136'd1);
        chk("bl1.sum",   136'(c_sum),   136'd9);
        set_in(1'b0, 64'd0, 1'b0, 1'b1); cycle();
        chk("bl1.drop", 136'(c_valid), 136'd0);

        // Randomized traffic checked against the model on all instances.
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 3) == 0) ? ONES : {$urandom, $urandom},
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 1) == 1);
            cycle();
        end
        rst = 1'b0;
        set_in(1'b0, 64'd0, 1'b0, 1'b1);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
